// File: rtl/imem_boot_ctrl.sv
// Boot/access controller: streams a program into instruction memory while holding the core in reset,
// then hands the single memory port to the IF stage. Writes land one cycle after acceptance; fetch is combinational.
module imem_boot_ctrl #(
   parameter int DEPTH = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        boot_start,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid,
   output logic        stall,
   output logic        fetch_misalign,
   output logic        cpu_rst_n,
   output logic        load_done,
   output logic        load_err,
   output logic [31:0] words_loaded,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_RUN   = 2'd3;

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   logic [1:0]  state;
   logic [31:0] wr_ptr;
   logic        wp;
   logic [31:0] wa;
   logic [31:0] wd;
   logic        in_run;
   logic        beat;
   logic        start_load;
   logic        in_range;

   assign in_run     = (state == S_RUN);
   assign ld_ready   = (state == S_LOAD);
   assign beat       = ld_valid & ld_ready;
   assign start_load = boot_start & ((state == S_IDLE) | in_run);
   assign in_range   = (wr_ptr < DEPTH_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (boot_start) state <= S_LOAD;
            S_LOAD:  if (beat && ld_last) state <= S_DRAIN;
            S_DRAIN: state <= S_RUN;
            S_RUN:   if (boot_start) state <= S_LOAD;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         words_loaded <= '0;
         load_err     <= 1'b0;
         load_done    <= 1'b0;
      end else if (start_load) begin
         wr_ptr       <= '0;
         words_loaded <= '0;
         load_err     <= 1'b0;
         load_done    <= 1'b0;
      end else begin
         if (beat) begin
            wr_ptr       <= wr_ptr + 32'd1;
            words_loaded <= words_loaded + 32'd1;
            if (!in_range) load_err <= 1'b1;
         end
         if (state == S_DRAIN) load_done <= 1'b1;
      end
   end

   // Pending write register: one slot is enough because the port writes every cycle it is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= 1'b0;
         wa <= '0;
         wd <= '0;
      end else if (beat && in_range) begin
         wp <= 1'b1;
         wa <= {wr_ptr[29:0], 2'b00};
         wd <= ld_data;
      end else begin
         wp <= 1'b0;
      end
   end

   // Core reset drops on the same edge that leaves RUN for a reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cpu_rst_n <= 1'b0;
      else        cpu_rst_n <= in_run & ~boot_start;
   end

   assign mem_wr    = wp;
   assign mem_addr  = wp ? wa : (in_run ? if_pc : 32'h0);
   assign mem_wdata = wp ? wd : 32'h0;

   assign stall          = ~in_run;
   assign fetch_misalign = in_run & if_req & (if_pc[1:0] != 2'b00);
   assign if_valid       = in_run & if_req & ~fetch_misalign;
   assign if_inst        = in_run ? mem_rdata : 32'h0;

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot and access controller for the core's word-addressed instruction memory. It shares the single memory port between two requesters: a program loader that streams 32-bit words in over a valid/ready handshake, and the IF stage fetch path. It holds the core in reset while a program is being loaded, then releases it and hands the memory port to fetch. It sits between the loader source, the IF stage and the instruction memory.

## Interface

Parameters:
- DEPTH, 10: memory capacity in 32-bit words; writes at word index ≥ DEPTH are dropped.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- boot_start  in  1  single-cycle request to begin or restart a program load.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  marks the final word of the program; qualified by ld_valid.
- ld_ready  out  1  controller can accept a loader word.
- if_req  in  1  IF stage fetch request.
- if_pc  in  32  fetch byte address.
- if_inst  out  32  fetched instruction.
- if_valid  out  1  if_inst is valid this cycle.
- stall  out  1  fetch not serviceable; IF must hold its PC.
- fetch_misalign  out  1  if_pc[1:0] != 0 during a RUN fetch.
- cpu_rst_n  out  1  active-low core reset, registered.
- load_done  out  1  a load has completed and RUN was entered; sticky.
- load_err  out  1  at least one word was dropped for overflow; sticky.
- words_loaded  out  32  count of words accepted in the current or last load.
- mem_wr  out  1  memory write enable.
- mem_addr  out  32  memory byte address; the memory divides it by 4.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

## Operation

- States: IDLE, LOAD, DRAIN, RUN.
- IDLE:
  - Reset state. cpu_rst_n=0, ld_ready=0, stall=1.
  - boot_start moves to LOAD. All other inputs are ignored.
- LOAD:
  - ld_ready=1, cpu_rst_n=0, stall=1.
  - Entry clears wr_ptr, words_loaded, load_err and load_done.
  - A beat is accepted when ld_valid=1 and ld_ready=1.
  - If wr_ptr < DEPTH: capture wa=wr_ptr<<2 and wd=ld_data, and set the pending write flag wp=1.
  - If wr_ptr ≥ DEPTH: drop the word (wp stays 0) and set load_err.
  - On every accepted beat, wr_ptr and words_loaded each increment by 1 (32-bit, no saturation needed).
  - An accepted beat with ld_last=1 moves to DRAIN.
  - boot_start is ignored in LOAD.
- DRAIN:
  - ld_ready=0. The last pending write completes this cycle; next state is RUN.
- RUN:
  - cpu_rst_n=1 (registered, so it is first seen high on the cycle after entry). load_done=1.
  - mem_addr=if_pc, mem_wr=0.
  - if_inst=mem_rdata; if_valid=if_req & ~fetch_misalign; stall=0.
  - boot_start returns to LOAD, and cpu_rst_n drops to 0 on the next edge.
- Memory port mux:
  - mem_wr=wp, mem_addr=wa, mem_wdata=wd whenever wp=1.
  - Otherwise, in RUN, mem_addr=if_pc.
  - wp clears on the edge after it is asserted, unless a new beat is accepted on that edge.
- Outside RUN, if_valid=0 and if_inst=0.

## Timing

- Reset values (asynchronous): state=IDLE, cpu_rst_n=0, ld_ready=0, wp=0, mem_wr=0, mem_addr=0, mem_wdata=0, if_valid=0, if_inst=0, stall=1, fetch_misalign=0, load_done=0, load_err=0, words_loaded=0.
- Write latency: a beat accepted at edge t drives mem_wr=1 during cycle t+1; the memory commits at edge t+2.
- Back-to-back beats sustain one write per cycle.
- Fetch latency: zero cycles (combinational through memory) in RUN.
- Last beat at edge t: DRAIN during cycle t+1, RUN from edge t+2, cpu_rst_n=1 from edge t+3.
- boot_start coincident with a loader beat in IDLE: the beat is not accepted (ld_ready=0). Loading starts the next cycle.
- Reset asserted mid-LOAD: returns to IDLE immediately, and the pending write is discarded (mem_wr=0 asynchronously).
- ld_last beat that overflows: load_err=1 and the transition to DRAIN still occurs.

## Test plan

- Reset, pulse boot_start, stream 4 words 0x00000013, 0x00100093, 0x00200113, 0x00308193 (last on the 4th) → mem_wr pulses with mem_addr 0x0,0x4,0x8,0xC; words_loaded=4; RUN 2 cycles after the last beat; cpu_rst_n=1 one cycle later.
- In RUN, if_req=1 with if_pc=0x8 → if_inst=0x00200113, if_valid=1, stall=0 in the same cycle.
- DEPTH=10, stream 12 words → 10 writes at addresses 0x0–0x24, load_err=1, words_loaded=12, RUN still reached.
- In RUN, if_pc=0x6 with if_req=1 → fetch_misalign=1, if_valid=0.
- In RUN, pulse boot_start → cpu_rst_n=0 next cycle, load_done and load_err cleared, ld_ready=1, new load overwrites from address 0x0.
- Assert rst_n=0 during the 2nd beat of a load → state=IDLE, mem_wr=0 immediately; after release, ld_ready stays 0 until boot_start.
